// File: rtl/base_hps_io_pkg.sv
// Shared constants and types for the HPS I/O conditioning blocks.
package base_hps_io_pkg;

  // System clock frequency the default debounce window is sized for.
  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  // 20 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Default counter width; 2**24 > DEBOUNCE_CYCLES_DEFAULT.
  localparam int unsigned CNT_W_DEFAULT = 24;

  // Per-bit debounce state.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } sw_state_t;

endpackage : base_hps_io_pkg

// File: rtl/base_hps_sw_debounce_bit.sv
// Single-bit switch conditioner: 2-FF synchronizer, debounce counter and
// two-state FSM. Edge pulse registers are built only when
// BASE_HPS_SW_DEBOUNCE_EDGE_EN is defined; otherwise sw_rise/sw_fall are 0.
module base_hps_sw_debounce_bit
  import base_hps_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  // Count value at which a pending change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  sw_state_t        state;
  sw_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             flip;

  // Two-flop synchronizer; s2 is the only copy the debounce logic sees.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // State, counter and accepted level registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_STABLE;
      cnt      <= '0;
      sw_clean <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flip) begin
        sw_clean <= s2;
      end
    end
  end

  // Next-state logic: count consecutive cycles where s2 differs from sw_clean.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flip      = 1'b0;
    unique case (state)
      ST_STABLE: begin
        if (s2 != sw_clean) begin
          state_nxt = ST_PENDING;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (s2 == sw_clean) begin
          // Bounce returned to the accepted level before the window closed.
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          flip      = 1'b1;
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BASE_HPS_SW_DEBOUNCE_EDGE_EN
  // Edge pulses registered from the flip decision, aligned with sw_clean.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= flip &  s2;
      sw_fall <= flip & ~s2;
    end
  end
`else
  assign sw_rise = 1'b0;
  assign sw_fall = 1'b0;
`endif

endmodule : base_hps_sw_debounce_bit

// File: rtl/base_hps_sw_debounce.sv
// Slide-switch conditioner feeding the HPS switch PIO in_port.
// One debounce slice per bit plus a global startup-settle counter.
// Optional edge pulses: define BASE_HPS_SW_DEBOUNCE_EDGE_EN.
module base_hps_sw_debounce
  import base_hps_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             stable_valid
);

  // One extra bit: the settle window is DEBOUNCE_CYCLES+2, which can reach 2**CNT_W.
  localparam int unsigned SW_W = CNT_W + 1;
  localparam logic [SW_W-1:0] START_LAST = SW_W'(DEBOUNCE_CYCLES + 1);

  logic [SW_W-1:0] start_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    base_hps_sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .sw_raw   (sw_raw[i]),
      .sw_clean (sw_clean[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i])
    );
  end

  // Startup window: stable_valid sets DEBOUNCE_CYCLES+2 cycles after reset release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_cnt    <= '0;
      stable_valid <= 1'b0;
    end else if (!stable_valid) begin
      if (start_cnt == START_LAST) begin
        stable_valid <= 1'b1;
      end else begin
        start_cnt <= start_cnt + SW_W'(1);
      end
    end
  end

endmodule : base_hps_sw_debounce
